// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer: entry-phase encoding,
// opcode width and debounce counter width.
package alu_seq_pkg;

  localparam int OP_W     = 3;
  localparam int DB_CNT_W = 24;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Board-side bundle for the operand sequencer. The switches and key go in,
// and the ALU operands plus the LED status come out.
// slave = sequencer side, master = board/stimulus side.
interface alu_operand_sequencer_if #(
  parameter int W = 8
);
  import alu_seq_pkg::*;

  logic [W-1:0]    sw_data;
  logic [OP_W-1:0] sw_op;
  logic            key_n;
  logic [W-1:0]    a_out;
  logic [W-1:0]    b_out;
  logic [OP_W-1:0] op_out;
  logic            operands_valid;
  logic [1:0]      phase;
  logic            key_down;

  modport master (
    output sw_data, sw_op, key_n,
    input  a_out, b_out, op_out, operands_valid, phase, key_down
  );

  modport slave (
    input  sw_data, sw_op, key_n,
    output a_out, b_out, op_out, operands_valid, phase, key_down
  );

endinterface

// File: rtl/alu_operand_sequencer_key_debounce.sv
// Push-button front end. It brings the raw active-low key into the clock
// domain through two flops and accepts a level change only after it has been
// stable for DEBOUNCE_CYCLES cycles. It emits a registered one-cycle pulse on
// each accepted press; a release produces no pulse.
module key_debounce
  import alu_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed_lvl,
  output logic press_pulse
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                db_lvl_q, db_lvl_d;
  logic                pulse_q, pulse_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  // Next-state logic. The count restarts whenever the input agrees with the
  // accepted level, so any glitch shorter than the window is forgotten.
  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    db_lvl_d = db_lvl_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (sync2_q != db_lvl_q) begin
      if (cnt_q == CNT_LAST) begin
        db_lvl_d = sync2_q;
        pulse_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers. The synchroniser and the accepted level reset to
  // "released", so a key held through reset is seen as a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      db_lvl_q <= 1'b1;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_lvl_q <= db_lvl_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pressed_lvl = ~db_lvl_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Operand entry sequencer for the 8-bit ALU demo. Each debounced key press
// steps through LOAD_A -> LOAD_B -> LOAD_OP -> SHOW and latches the switch
// bank into the register for the current step.
// Optional macro ALU_SEQ_LIVE_PREVIEW_EN: while in LOAD_A or LOAD_B, the
// operand being entered follows the switches every cycle.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W               = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic                    clk,
  input logic                    rst,
  alu_operand_sequencer_if.slave bus
);

  logic            press;
  logic            key_down;
  seq_state_e      state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            valid_q, valid_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk        (clk),
    .rst        (rst),
    .key_n      (bus.key_n),
    .pressed_lvl(key_down),
    .press_pulse(press)
  );

  // Entry FSM. Only the register that belongs to the current phase is ever
  // written. A press from SHOW clears the valid flag but keeps the values.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
`ifdef ALU_SEQ_LIVE_PREVIEW_EN
    if (state_q == LOAD_A) a_d = bus.sw_data;
    if (state_q == LOAD_B) b_d = bus.sw_data;
`endif
    if (press) begin
      unique case (state_q)
        LOAD_A: begin
          a_d     = bus.sw_data;
          state_d = LOAD_B;
        end
        LOAD_B: begin
          b_d     = bus.sw_data;
          state_d = LOAD_OP;
        end
        LOAD_OP: begin
          op_d    = bus.sw_op;
          valid_d = 1'b1;
          state_d = SHOW;
        end
        SHOW: begin
          valid_d = 1'b0;
          state_d = LOAD_A;
        end
      endcase
    end
  end

  // Registered outputs, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  assign bus.a_out          = a_q;
  assign bus.b_out          = b_q;
  assign bus.op_out         = op_q;
  assign bus.operands_valid = valid_q;
  assign bus.phase          = state_q;
  assign bus.key_down       = key_down;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed testbench for alu_operand_sequencer with a short debounce window
// (DEBOUNCE_CYCLES=4). It honours ALU_SEQ_LIVE_PREVIEW_EN when that macro is
// defined for the build.
module tb_alu_operand_sequencer;
  import alu_seq_pkg::*;

  localparam int W  = 8;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors    = 0;
  int   checks    = 0;
  int   pulse_cnt = 0;

  alu_operand_sequencer_if #(.W(W)) bus ();

  alu_operand_sequencer #(
    .W(W),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Count press pulses away from the active edge
  always @(negedge clk) begin
    if (dut.press === 1'b1) pulse_cnt++;
  end

  // Advance n clock edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One clean press and release, long enough to pass the debounce window
  task automatic press_key();
    bus.key_n = 1'b0;
    tick(DB + 8);
    bus.key_n = 1'b1;
    tick(DB + 8);
  endtask

  // Reset values, then a quiet key must produce no pulse
  task automatic test_reset();
    rst = 1'b1;
    bus.key_n = 1'b1;
    bus.sw_data = '0;
    bus.sw_op = '0;
    tick(3);
    rst = 1'b0;
    checks++; if (bus.a_out !== 8'h00) begin errors++; $display("[TB] FAIL rst_a: got %h want 00", bus.a_out); end
    checks++; if (bus.b_out !== 8'h00) begin errors++; $display("[TB] FAIL rst_b: got %h want 00", bus.b_out); end
    checks++; if (bus.op_out !== 3'd0) begin errors++; $display("[TB] FAIL rst_op: got %0d want 0", bus.op_out); end
    checks++; if (bus.operands_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b want 0", bus.operands_valid); end
    checks++; if (bus.phase !== 2'd0) begin errors++; $display("[TB] FAIL rst_phase: got %0d want 0", bus.phase); end
    pulse_cnt = 0;
    tick(20);
    checks++; if (pulse_cnt !== 0) begin errors++; $display("[TB] FAIL rst_no_pulse: got %0d want 0", pulse_cnt); end
    checks++; if (bus.phase !== 2'd0) begin errors++; $display("[TB] FAIL rst_idle_phase: got %0d want 0", bus.phase); end
  endtask

  // A, B and op entered in turn, then a fourth press leaves SHOW
  task automatic test_full_sequence();
    logic [W-1:0] exp_a;
    bus.sw_data = 8'h3C;
    press_key();
    checks++; if (bus.phase !== 2'd1) begin errors++; $display("[TB] FAIL seq_phase1: got %0d want 1", bus.phase); end
    checks++; if (bus.a_out !== 8'h3C) begin errors++; $display("[TB] FAIL seq_a: got %h want 3c", bus.a_out); end
    bus.sw_data = 8'hA5;
    press_key();
    checks++; if (bus.phase !== 2'd2) begin errors++; $display("[TB] FAIL seq_phase2: got %0d want 2", bus.phase); end
    checks++; if (bus.b_out !== 8'hA5) begin errors++; $display("[TB] FAIL seq_b: got %h want a5", bus.b_out); end
    checks++; if (bus.operands_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_valid_early: got %b want 0", bus.operands_valid); end
    bus.sw_op = 3'b010;
    press_key();
    checks++; if (bus.phase !== 2'd3) begin errors++; $display("[TB] FAIL seq_phase3: got %0d want 3", bus.phase); end
    checks++; if (bus.operands_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid: got %b want 1", bus.operands_valid); end
    checks++; if (bus.op_out !== 3'd2) begin errors++; $display("[TB] FAIL seq_op: got %0d want 2", bus.op_out); end
    checks++; if (bus.a_out !== 8'h3C) begin errors++; $display("[TB] FAIL seq_a_show: got %h want 3c", bus.a_out); end
    checks++; if (bus.b_out !== 8'hA5) begin errors++; $display("[TB] FAIL seq_b_show: got %h want a5", bus.b_out); end
    press_key();
`ifdef ALU_SEQ_LIVE_PREVIEW_EN
    exp_a = 8'hA5;
`else
    exp_a = 8'h3C;
`endif
    checks++; if (bus.phase !== 2'd0) begin errors++; $display("[TB] FAIL seq_wrap_phase: got %0d want 0", bus.phase); end
    checks++; if (bus.operands_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_wrap_valid: got %b want 0", bus.operands_valid); end
    checks++; if (bus.a_out !== exp_a) begin errors++; $display("[TB] FAIL seq_wrap_a: got %h want %h", bus.a_out, exp_a); end
    checks++; if (bus.b_out !== 8'hA5) begin errors++; $display("[TB] FAIL seq_wrap_b: got %h want a5", bus.b_out); end
    checks++; if (bus.op_out !== 3'd2) begin errors++; $display("[TB] FAIL seq_wrap_op: got %0d want 2", bus.op_out); end
  endtask

  // Bouncing key: only the final steady low is accepted, 6 cycles later
  task automatic test_bounce();
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.key_n = 1'b0;
      tick(2);
      bus.key_n = 1'b1;
      tick(2);
    end
    checks++; if (pulse_cnt !== p0) begin errors++; $display("[TB] FAIL bounce_reject: got %0d pulses want 0", pulse_cnt - p0); end
    bus.key_n = 1'b0;
    tick(5);
    checks++; if (dut.press !== 1'b0) begin errors++; $display("[TB] FAIL bounce_early: got %b want 0", dut.press); end
    tick(1);
    checks++; if (dut.press !== 1'b1) begin errors++; $display("[TB] FAIL bounce_latency: got %b want 1", dut.press); end
    checks++; if (bus.phase !== 2'd0) begin errors++; $display("[TB] FAIL bounce_phase_hold: got %0d want 0", bus.phase); end
    tick(1);
    checks++; if (bus.phase !== 2'd1) begin errors++; $display("[TB] FAIL bounce_phase_adv: got %0d want 1", bus.phase); end
    bus.key_n = 1'b1;
    tick(DB + 8);
    checks++; if (pulse_cnt !== p0 + 1) begin errors++; $display("[TB] FAIL bounce_one_pulse: got %0d want 1", pulse_cnt - p0); end
    checks++; if (bus.phase !== 2'd1) begin errors++; $display("[TB] FAIL bounce_release: got %0d want 1", bus.phase); end
  endtask

  // Long hold advances once; a fresh press after release advances again
  task automatic test_held_key();
    int p0;
    p0 = pulse_cnt;
    bus.key_n = 1'b0;
    tick(200);
    checks++; if (bus.phase !== 2'd2) begin errors++; $display("[TB] FAIL held_phase: got %0d want 2", bus.phase); end
    checks++; if (pulse_cnt !== p0 + 1) begin errors++; $display("[TB] FAIL held_pulses: got %0d want 1", pulse_cnt - p0); end
    bus.key_n = 1'b1;
    tick(10);
    checks++; if (bus.phase !== 2'd2) begin errors++; $display("[TB] FAIL held_release: got %0d want 2", bus.phase); end
    bus.key_n = 1'b0;
    tick(DB + 8);
    checks++; if (bus.phase !== 2'd3) begin errors++; $display("[TB] FAIL held_second: got %0d want 3", bus.phase); end
    checks++; if (bus.operands_valid !== 1'b1) begin errors++; $display("[TB] FAIL held_valid: got %b want 1", bus.operands_valid); end
    bus.key_n = 1'b1;
    tick(DB + 8);
  endtask

  // Reset in LOAD_B with a debounce count part-way through
  task automatic test_reset_mid_entry();
    int p0;
    press_key();
    bus.sw_data = 8'h5A;
    press_key();
    checks++; if (bus.a_out !== 8'h5A) begin errors++; $display("[TB] FAIL mid_a_loaded: got %h want 5a", bus.a_out); end
    bus.key_n = 1'b0;
    tick(4);
    rst = 1'b1;
    bus.key_n = 1'b1;
    tick(2);
    rst = 1'b0;
    p0 = pulse_cnt;
    checks++; if (bus.a_out !== 8'h00) begin errors++; $display("[TB] FAIL mid_a: got %h want 00", bus.a_out); end
    checks++; if (bus.b_out !== 8'h00) begin errors++; $display("[TB] FAIL mid_b: got %h want 00", bus.b_out); end
    checks++; if (bus.op_out !== 3'd0) begin errors++; $display("[TB] FAIL mid_op: got %0d want 0", bus.op_out); end
    checks++; if (bus.phase !== 2'd0) begin errors++; $display("[TB] FAIL mid_phase: got %0d want 0", bus.phase); end
    tick(20);
    checks++; if (pulse_cnt !== p0) begin errors++; $display("[TB] FAIL mid_stray: got %0d pulses want 0", pulse_cnt - p0); end
    checks++; if (bus.phase !== 2'd0) begin errors++; $display("[TB] FAIL mid_phase_idle: got %0d want 0", bus.phase); end
  endtask

  // Live preview of operand A in LOAD_A (or no change without the feature)
  task automatic test_live_preview();
    logic [W-1:0] exp1, exp2;
`ifdef ALU_SEQ_LIVE_PREVIEW_EN
    exp1 = 8'h11;
    exp2 = 8'h22;
`else
    exp1 = 8'h00;
    exp2 = 8'h00;
`endif
    bus.sw_data = 8'h11;
    tick(1);
    checks++; if (bus.a_out !== exp1) begin errors++; $display("[TB] FAIL preview_11: got %h want %h", bus.a_out, exp1); end
    bus.sw_data = 8'h22;
    #2;
    checks++; if (bus.a_out !== exp1) begin errors++; $display("[TB] FAIL preview_latency: got %h want %h", bus.a_out, exp1); end
    tick(1);
    checks++; if (bus.a_out !== exp2) begin errors++; $display("[TB] FAIL preview_22: got %h want %h", bus.a_out, exp2); end
  endtask

  // Key held low through reset yields one press DB+2 cycles after release
  task automatic test_held_through_reset();
    bus.key_n = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(DB + 2);
    checks++; if (bus.phase !== 2'd0) begin errors++; $display("[TB] FAIL hold_rst_early: got %0d want 0", bus.phase); end
    tick(1);
    checks++; if (bus.phase !== 2'd1) begin errors++; $display("[TB] FAIL hold_rst_press: got %0d want 1", bus.phase); end
    bus.key_n = 1'b1;
    tick(DB + 8);
  endtask

  // Scenario sequence and summary
  initial begin
    rst = 1'b1;
    bus.key_n = 1'b1;
    bus.sw_data = '0;
    bus.sw_op = '0;
    test_reset();
    test_full_sequence();
    test_bounce();
    test_held_key();
    test_reset_mid_entry();
    test_live_preview();
    test_held_through_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
